// File: rtl/mul_iter.sv
// Multi-cycle radix-4 Booth multiplier for the EXE-stage mul/mulh/mulhu path.
// One Booth partial product is accumulated per cycle. The block has valid/ready, flush and a zero-operand early-out.
module mul_iter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ZERO_SKIP = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic                 in_high,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic [2*WIDTH-1:0]   out_prod
);

  localparam int unsigned EW = WIDTH + 2;
  localparam int unsigned N  = EW / 2;
  localparam int unsigned AW = 2 * WIDTH + 2;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [AW-1:0]    r_mc;
  logic [AW-1:0]    r_acc;
  logic [EW:0]      r_y;
  logic             r_high;
  logic [WIDTH-1:0] r_result;

  logic             w_fire;
  logic             w_zero;
  logic             w_last;
  logic             w_neg;
  logic [AW-1:0]    w_pp;
  logic [AW-1:0]    w_acc_nxt;
  logic [EW-1:0]    w_xe;
  logic [EW-1:0]    w_ye;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_fire) w_state_nxt = w_zero ? S_DONE : S_CALC;
        S_CALC: if (w_last) w_state_nxt = S_DONE;
        S_DONE: if (out_ready) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs and control decoded from the state register
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    w_fire    = in_valid && (r_state == S_IDLE) && !flush;
    w_zero    = (ZERO_SKIP != 0) && ((in_x == '0) || (in_y == '0));
    w_last    = (r_state == S_CALC) && (r_cnt == CW'(N - 1));
  end

  assign w_xe = {{2{in_sign & in_x[WIDTH-1]}}, in_x};
  assign w_ye = {{2{in_sign & in_y[WIDTH-1]}}, in_y};

  // Booth digit select; negation is ~X with the carry-in folded into the add
  always_comb begin
    w_pp  = '0;
    w_neg = 1'b0;
    case (r_y[2:0])
      3'b001, 3'b010: w_pp = r_mc;
      3'b011:         w_pp = r_mc << 1;
      3'b100: begin
        w_pp  = ~(r_mc << 1);
        w_neg = 1'b1;
      end
      3'b101, 3'b110: begin
        w_pp  = ~r_mc;
        w_neg = 1'b1;
      end
      default: w_pp = '0;
    endcase
  end

  assign w_acc_nxt = r_acc + w_pp + AW'(w_neg);

  // Datapath: operand capture, per-step accumulate, result latch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_mc     <= '0;
      r_acc    <= '0;
      r_y      <= '0;
      r_high   <= 1'b0;
      r_result <= '0;
    end else if (flush) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_fire) begin
      r_mc   <= {{(AW-EW){w_xe[EW-1]}}, w_xe};
      r_y    <= {w_ye, 1'b0};
      r_high <= in_high;
      r_acc  <= '0;
      r_cnt  <= '0;
      if (w_zero) r_result <= '0;
    end else if (r_state == S_CALC) begin
      r_acc <= w_acc_nxt;
      r_mc  <= r_mc << 2;
      r_y   <= {{2{r_y[EW]}}, r_y[EW:2]};
      r_cnt <= r_cnt + CW'(1);
      if (w_last)
        r_result <= r_high ? w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[WIDTH-1:0];
    end
  end

  assign out_prod   = r_acc[2*WIDTH-1:0];
  assign out_result = r_result;

endmodule

// File: tb/tb_mul_iter.sv
// Directed and constrained-random bench for mul_iter (WIDTH=32, ZERO_SKIP=1).
module tb_mul_iter;
  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           reset, flush, in_valid, in_ready, in_sign, in_high;
  logic           out_valid, out_ready;
  logic [W-1:0]   in_x, in_y, out_result;
  logic [2*W-1:0] out_prod;
  int             n_chk = 0;
  int             n_err = 0;

  mul_iter #(.WIDTH(W), .ZERO_SKIP(1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_high(in_high), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_prod(out_prod)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [63:0] a, b;
    a = s ? {{32{x[31]}}, x} : {32'b0, x};
    b = s ? {{32{y[31]}}, y} : {32'b0, y};
    return a * b;
  endfunction

  // Fire one request; returns at the falling edge of cycle 1 with garbage on the operand pins
  task automatic start(input logic [31:0] x, input logic [31:0] y, input logic s, input logic h);
    @(negedge clk);
    check("start_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_x = x; in_y = y; in_sign = s; in_high = h;
    @(negedge clk);
    in_valid = 1'b0; in_x = $urandom; in_y = $urandom; in_sign = $urandom; in_high = $urandom;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) check("timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic s, input logic h, input logic [63:0] ep,
                        input logic [31:0] er, input int lat);
    int cyc;
    start(x, y, s, h);
    wait_done(cyc);
    check({tag, "_lat"}, 64'(cyc), 64'(lat));
    check({tag, "_prod"}, out_prod, ep);
    check({tag, "_res"}, 64'(out_result), 64'(er));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [63:0] p;
    logic [31:0] x, y;
    logic s, h;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_sign = 1'b0; in_high = 1'b0; in_x = '0; in_y = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_prod", out_prod, 64'd0);
    check("rst_res", 64'(out_result), 64'd0);

    run_op("max_lo", 32'h7FFFFFFF, 32'h7FFFFFFF, 1, 0, 64'h3FFFFFFF00000001, 32'h00000001, 18);
    run_op("max_hi", 32'h7FFFFFFF, 32'h7FFFFFFF, 1, 1, 64'h3FFFFFFF00000001, 32'h3FFFFFFF, 18);
    run_op("m1_s", 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 64'h0000000000000001, 32'h00000001, 18);
    run_op("m1_u", 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 64'hFFFFFFFE00000001, 32'hFFFFFFFE, 18);
    run_op("min_s", 32'h80000000, 32'h80000000, 1, 1, 64'h4000000000000000, 32'h40000000, 18);
    run_op("neg2x3", 32'hFFFFFFFE, 32'h00000003, 1, 0, 64'hFFFFFFFFFFFFFFFA, 32'hFFFFFFFA, 18);
    run_op("zskip", 32'h00000000, 32'h12345678, 0, 0, 64'd0, 32'd0, 1);

    // Backpressure: outputs frozen, no new request accepted
    start(32'h10, 32'h20, 0, 0);
    wait_done(cyc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_prod", out_prod, 64'h200);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    check("bp_hs_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_post_in_ready", 64'(in_ready), 64'd1);
    check("bp_post_valid", 64'(out_valid), 64'd0);

    // Flush at CALC step 7, then a clean op
    start(32'd123, 32'd456, 0, 0);
    repeat (6) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    repeat (20) @(negedge clk);
    check("fl_still_idle", 64'(out_valid), 64'd0);
    run_op("post_fl", 32'd5, 32'd7, 0, 0, 64'd35, 32'd35, 18);

    // Flush with in_valid in IDLE must not accept
    in_valid = 1'b1; flush = 1'b1; in_x = 32'd3; in_y = 32'd3;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flv_in_ready", 64'(in_ready), 64'd1);
    check("flv_valid", 64'(out_valid), 64'd0);

    // Flush together with the result handshake
    start(32'd9, 32'd9, 0, 0);
    wait_done(cyc);
    out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; flush = 1'b0;
    check("fld_valid", 64'(out_valid), 64'd0);
    check("fld_in_ready", 64'(in_ready), 64'd1);

    // Reset at step 3
    start(32'h1234, 32'h5678, 0, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mr_in_ready", 64'(in_ready), 64'd1);
    check("mr_valid", 64'(out_valid), 64'd0);
    check("mr_prod", out_prod, 64'd0);
    check("mr_res", 64'(out_result), 64'd0);
    run_op("post_rst", 32'hFFFFFFFB, 32'd7, 1, 0, 64'hFFFFFFFFFFFFFFDD, 32'hFFFFFFDD, 18);

    // Random ops with stalls and flushes
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 7))
        0: x = 32'h80000000;
        1: x = 32'h0;
        2: x = 32'hFFFFFFFF;
        default: x = $urandom;
      endcase
      y = ($urandom_range(0, 7) == 0) ? 32'h7FFFFFFF : $urandom;
      s = $urandom; h = $urandom;
      p = ref_mul(x, y, s);
      start(x, y, s, h);
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, 19)) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("rnd_flush", 64'(out_valid), 64'd0);
      end else begin
        wait_done(cyc);
        check("rnd_lat", 64'(cyc), (x == 0 || y == 0) ? 64'd1 : 64'd18);
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          check("rnd_stall", 64'(out_valid), 64'd1);
        end
        check("rnd_prod", out_prod, p);
        check("rnd_res", 64'(out_result), h ? 64'(p[63:32]) : 64'(p[31:0]));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
